// File: rtl/bus_xbar_pkg.sv
// bus_xbar_pkg: shared types, constants and width helpers for the bus_xbar
// crossbar and its per-slave round-robin arbiters.
//   idx_width()  - slave-index field width for a given slave count
//   ptr_width()  - arbiter pointer width for a given master count
//   DECERR_DATA  - read data returned for decode-error reads (BUS_XBAR_DECERR_EN)
//   req_kind_e   - per-master request kind after read/write priority
package bus_xbar_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_RD   = 2'd1,
        REQ_WR   = 2'd2
    } req_kind_e;

    localparam logic [63:0] DECERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    function automatic int idx_width(input int n_s);
        return (n_s > 1) ? $clog2(n_s) : 1;
    endfunction

    function automatic int ptr_width(input int n_m);
        return (n_m > 1) ? $clog2(n_m) : 1;
    endfunction

endpackage

// File: rtl/bus_xbar_if.sv
// bus_xbar_if: master-side and slave-side signal bundle of the crossbar.
//   master modport - view of the requesting masters (drive en/addr/data/sel)
//   slave modport  - view of the memory slaves (consume enables, drive s_rdata)
//   xbar modport   - view of the crossbar itself
// Vectors are flat: master i occupies [i*W +: W], slave s occupies [s*W +: W].
// m_err exists only when BUS_XBAR_DECERR_EN is defined.
interface bus_xbar_if #(
    parameter int NUM_M = 3,
    parameter int NUM_S = 8,
    parameter int AW    = 64,
    parameter int DW    = 64,
    parameter int SW    = DW / 8
);
    logic [NUM_M-1:0]    m_en_r;
    logic [NUM_M-1:0]    m_en_w;
    logic [NUM_M*AW-1:0] m_addr_r;
    logic [NUM_M*AW-1:0] m_addr_w;
    logic [NUM_M*DW-1:0] m_data_w;
    logic [NUM_M*SW-1:0] m_sel_w;
    logic [NUM_M-1:0]    m_stall;
    logic [NUM_M*DW-1:0] m_rdata;
    logic [NUM_M-1:0]    m_r_valid;
`ifdef BUS_XBAR_DECERR_EN
    logic [NUM_M-1:0]    m_err;
`endif
    logic [NUM_S-1:0]    s_rena;
    logic [NUM_S*AW-1:0] s_raddr;
    logic [NUM_S*DW-1:0] s_rdata;
    logic [NUM_S-1:0]    s_wena;
    logic [NUM_S*AW-1:0] s_waddr;
    logic [NUM_S*DW-1:0] s_wdata;
    logic [NUM_S*SW-1:0] s_wsel;

    modport master (
`ifdef BUS_XBAR_DECERR_EN
        input  m_err,
`endif
        output m_en_r, m_en_w, m_addr_r, m_addr_w, m_data_w, m_sel_w,
        input  m_stall, m_rdata, m_r_valid
    );

    modport slave (
        input  s_rena, s_raddr, s_wena, s_waddr, s_wdata, s_wsel,
        output s_rdata
    );

    modport xbar (
`ifdef BUS_XBAR_DECERR_EN
        output m_err,
`endif
        input  m_en_r, m_en_w, m_addr_r, m_addr_w, m_data_w, m_sel_w,
        output m_stall, m_rdata, m_r_valid,
        output s_rena, s_raddr, s_wena, s_waddr, s_wdata, s_wsel,
        input  s_rdata
    );
endinterface

// File: rtl/bus_xbar_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter, one per crossbar slave.
//   clk, rst_n - clock, asynchronous active-low reset (pointer -> 0)
//   req[N]     - requesting masters
//   advance    - move the pointer past the winner when a grant is issued
//   grant[N]   - one-hot grant, combinational in the request cycle
//   ptr        - current highest-priority master
module rr_arbiter
    import bus_xbar_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = ptr_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] ptr
);
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] winner_s;
    logic          found_s;

    // Pick the first requester at rotational distance 0, 1, ... from the pointer
    always_comb begin
        grant    = '0;
        winner_s = ptr_r;
        found_s  = 1'b0;
        for (int d = 0; d < N; d++) begin
            for (int j = 0; j < N; j++) begin
                if (!found_s && req[j] && (((j + N - int'(ptr_r)) % N) == d)) begin
                    grant[j] = 1'b1;
                    winner_s = PW'(j);
                    found_s  = 1'b1;
                end else begin
                    grant[j] = grant[j];
                end
            end
        end
    end

    // Pointer moves to winner+1 (mod N) on a grant, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (advance && found_s) begin
            ptr_r <= (int'(winner_s) == N - 1) ? '0 : winner_s + PW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/bus_xbar.sv
// bus_xbar: NUM_M x NUM_S memory-mapped crossbar with a round-robin arbiter
// per slave. Slave index = top IDX_W address bits; the forwarded slave
// address has that field cleared. Writes complete in the grant cycle; read
// data is captured at the end of the grant cycle and presented with a
// one-cycle m_r_valid pulse. A master raising en_w and en_r together has
// its write issued and is stalled so it re-presents the read.
//   aclk, rst_n - clock, asynchronous active-low reset
//   bus         - bus_xbar_if.xbar (master request/response and slave ports)
// Optional: BUS_XBAR_DECERR_EN - out-of-range indexes and reads with top
// nibble 4'hF are answered locally (DECERR_DATA, m_err pulse) instead of
// wrapping the index onto a real slave.
module bus_xbar
    import bus_xbar_pkg::*;
#(
    parameter int NUM_M = 3,
    parameter int NUM_S = 8,
    parameter int AW    = 64,
    parameter int DW    = 64,
    parameter int SW    = DW / 8,
    parameter int IDX_W = idx_width(NUM_S)
) (
    input  logic     aclk,
    input  logic     rst_n,
    bus_xbar_if.xbar bus
);
    localparam logic [AW-1:0] IDX_MASK = {{IDX_W{1'b1}}, {(AW - IDX_W){1'b0}}};

    req_kind_e           kind_s  [NUM_M];
    logic [AW-1:0]       addr_s  [NUM_M];
    logic [IDX_W-1:0]    tgt_s   [NUM_M];
    logic [NUM_M-1:0]    decerr_s;
    logic [NUM_M-1:0]    req_s   [NUM_S];
    logic [NUM_M-1:0]    grant_s [NUM_S];
    logic [NUM_M-1:0]    gnt_m_s;
    logic [NUM_M-1:0]    rd_done_s;
    logic [NUM_M*DW-1:0] rdata_nxt_s;
    logic [NUM_M*DW-1:0] m_rdata_r;
    logic [NUM_M-1:0]    m_r_valid_r;

    // Per-master request: write wins over a simultaneous read
    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            if (bus.m_en_w[i]) begin
                kind_s[i] = REQ_WR;
                addr_s[i] = bus.m_addr_w[i*AW +: AW];
            end else if (bus.m_en_r[i]) begin
                kind_s[i] = REQ_RD;
                addr_s[i] = bus.m_addr_r[i*AW +: AW];
            end else begin
                kind_s[i] = REQ_NONE;
                addr_s[i] = '0;
            end
            tgt_s[i] = IDX_W'(int'(addr_s[i][AW-1 -: IDX_W]) % NUM_S);
`ifdef BUS_XBAR_DECERR_EN
            decerr_s[i] = (kind_s[i] != REQ_NONE) &&
                          ((int'(addr_s[i][AW-1 -: IDX_W]) >= NUM_S) ||
                           ((kind_s[i] == REQ_RD) && (addr_s[i][AW-1 -: 4] == 4'hF)));
`else
            decerr_s[i] = 1'b0;
`endif
        end
    end

    // Route each decodable request to its target slave's arbiter
    always_comb begin
        for (int s = 0; s < NUM_S; s++) begin
            req_s[s] = '0;
            for (int i = 0; i < NUM_M; i++) begin
                req_s[s][i] = (kind_s[i] != REQ_NONE) && !decerr_s[i] && (tgt_s[i] == IDX_W'(s));
            end
        end
    end

    for (genvar s = 0; s < NUM_S; s++) begin : g_arb
        rr_arbiter #(.N(NUM_M)) u_arb (
            .clk     (aclk),
            .rst_n   (rst_n),
            .req     (req_s[s]),
            .advance (|req_s[s]),
            .grant   (grant_s[s]),
            .ptr     ()
        );
    end

    // Drive each slave from its winner only, and derive per-master stall
    always_comb begin
        bus.s_rena  = '0;
        bus.s_raddr = '0;
        bus.s_wena  = '0;
        bus.s_waddr = '0;
        bus.s_wdata = '0;
        bus.s_wsel  = '0;
        gnt_m_s     = '0;
        for (int s = 0; s < NUM_S; s++) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (grant_s[s][i]) begin
                    gnt_m_s[i] = 1'b1;
                    if (kind_s[i] == REQ_WR) begin
                        bus.s_wena[s]              = 1'b1;
                        bus.s_waddr[s*AW +: AW]    = addr_s[i] & ~IDX_MASK;
                        bus.s_wdata[s*DW +: DW]    = bus.m_data_w[i*DW +: DW];
                        bus.s_wsel[s*SW +: SW]     = bus.m_sel_w[i*SW +: SW];
                    end else begin
                        bus.s_rena[s]              = 1'b1;
                        bus.s_raddr[s*AW +: AW]    = addr_s[i] & ~IDX_MASK;
                    end
                end else begin
                    gnt_m_s[i] = gnt_m_s[i];
                end
            end
        end
        for (int i = 0; i < NUM_M; i++) begin
            // A deferred read (en_w && en_r) stalls even when the write is granted
            bus.m_stall[i] = ((kind_s[i] != REQ_NONE) && !gnt_m_s[i] && !decerr_s[i]) ||
                             (bus.m_en_w[i] && bus.m_en_r[i]);
        end
    end

    // Select the read data each master captures at the end of this cycle
    always_comb begin
        rd_done_s   = '0;
        rdata_nxt_s = m_rdata_r;
        for (int s = 0; s < NUM_S; s++) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (grant_s[s][i] && (kind_s[i] == REQ_RD)) begin
                    rd_done_s[i]             = 1'b1;
                    rdata_nxt_s[i*DW +: DW]  = bus.s_rdata[s*DW +: DW];
                end else begin
                    rd_done_s[i] = rd_done_s[i];
                end
            end
        end
`ifdef BUS_XBAR_DECERR_EN
        for (int i = 0; i < NUM_M; i++) begin
            if (decerr_s[i] && (kind_s[i] == REQ_RD)) begin
                rd_done_s[i]            = 1'b1;
                rdata_nxt_s[i*DW +: DW] = DW'(DECERR_DATA);
            end else begin
                rd_done_s[i] = rd_done_s[i];
            end
        end
`endif
    end

    // Read-response registers: data held between reads, valid is a pulse
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdata_r   <= '0;
            m_r_valid_r <= '0;
        end else begin
            m_rdata_r   <= rdata_nxt_s;
            m_r_valid_r <= rd_done_s;
        end
    end

    assign bus.m_rdata   = m_rdata_r;
    assign bus.m_r_valid = m_r_valid_r;

`ifdef BUS_XBAR_DECERR_EN
    logic [NUM_M-1:0] m_err_r;

    // Decode-error flag, one cycle after the offending request
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            m_err_r <= '0;
        end else begin
            m_err_r <= decerr_s;
        end
    end

    assign bus.m_err = m_err_r;
`endif

endmodule

// File: tb/tb_bus_xbar.sv
// tb_bus_xbar: directed self-checking bench for bus_xbar (3 masters, 8 slaves).
// Read responses are predicted into a scoreboard queue when a read is driven
// and compared when m_r_valid is due; slave grants, addresses and stalls are
// checked in the request cycle.
module tb_bus_xbar;
    localparam int NUM_M = 3;
    localparam int NUM_S = 8;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int SW    = 8;
    localparam logic [63:0] LOW_MASK = 64'h1FFF_FFFF_FFFF_FFFF;

    typedef struct {
        int          due;
        int          m;
        logic [63:0] d;
    } sb_t;

    logic aclk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_err;
    sb_t  sb[$];

    bus_xbar_if #(.NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .SW(SW)) bus ();

    bus_xbar #(.NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .SW(SW)) dut (
        .aclk  (aclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [63:0] slave_fn(input logic [2:0] s, input logic [63:0] a);
        return {13'h0, s, 48'h0} ^ a ^ 64'h1224;
    endfunction

    // Slave memory model: combinational read data from the forwarded address
    always_comb begin
        bus.s_rdata = '0;
        for (int s = 0; s < NUM_S; s++) begin
            bus.s_rdata[s*64 +: 64] = slave_fn(3'(s), bus.s_raddr[s*64 +: 64]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.m_en_r   = '0;
        bus.m_en_w   = '0;
        bus.m_addr_r = '0;
        bus.m_addr_w = '0;
        bus.m_data_w = '0;
        bus.m_sel_w  = '0;
    endtask

    task automatic rd(input int m, input logic [63:0] a);
        bus.m_en_r[m]          = 1'b1;
        bus.m_addr_r[m*64 +: 64] = a;
    endtask

    task automatic wr(input int m, input logic [63:0] a, input logic [63:0] d, input logic [7:0] sel);
        bus.m_en_w[m]            = 1'b1;
        bus.m_addr_w[m*64 +: 64] = a;
        bus.m_data_w[m*64 +: 64] = d;
        bus.m_sel_w[m*8 +: 8]    = sel;
    endtask

    task automatic push_val(input int m, input logic [63:0] d);
        sb_t e;
        e.due = cyc + 1;
        e.m   = m;
        e.d   = d;
        sb.push_back(e);
    endtask

    task automatic push(input int m, input logic [63:0] a);
        push_val(m, slave_fn(a[63:61], a & LOW_MASK));
    endtask

    // Sample mid-cycle: check valid pulses and data against the scoreboard
    task automatic mid();
        logic [NUM_M-1:0] exp_v;
        sb_t e;
        @(negedge aclk);
        exp_v = '0;
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].due == cyc) exp_v[sb[k].m] = 1'b1;
        end
        chk("r_valid", 64'(bus.m_r_valid), 64'(exp_v));
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk($sformatf("rdata_m%0d", e.m), bus.m_rdata[e.m*64 +: 64], e.d);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    initial begin
        cyc   = 0;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        rst_n = 1'b1;
        tick();

        // Reset state
        mid();
        for (int m = 0; m < NUM_M; m++) chk("reset_rdata", bus.m_rdata[m*64 +: 64], 64'h0);
        chk("reset_stall", 64'(bus.m_stall), 64'h0);
        chk("reset_rena", 64'(bus.s_rena), 64'h0);
        chk("reset_wena", 64'(bus.s_wena), 64'h0);
        tick();

        // Single read, latency and hold
        rd(0, 64'h0000_0000_0000_0010);
        push(0, 64'h0000_0000_0000_0010);
        mid();
        chk("rd_rena", 64'(bus.s_rena), 64'h01);
        chk("rd_raddr0", bus.s_raddr[0 +: 64], 64'h10);
        chk("rd_stall", 64'(bus.m_stall), 64'h0);
        tick();
        idle();
        mid();
        chk("rd_data", bus.m_rdata[0 +: 64], 64'h1234);
        tick();
        mid();
        chk("rd_hold", bus.m_rdata[0 +: 64], 64'h1234);
        tick();

        // Back-to-back reads, same master and slave
        rd(0, 64'h0000_0000_0000_0030);
        push(0, 64'h0000_0000_0000_0030);
        mid();
        tick();
        rd(0, 64'h0000_0000_0000_0038);
        push(0, 64'h0000_0000_0000_0038);
        mid();
        tick();
        idle();
        mid();
        tick();

        // M0 and M1 contend for slave1: grants alternate
        rd(0, 64'h2000_0000_0000_0100);
        rd(1, 64'h2000_0000_0000_0200);
        for (int k = 0; k < 4; k++) begin
            push(k % 2, (k % 2 == 0) ? 64'h2000_0000_0000_0100 : 64'h2000_0000_0000_0200);
            mid();
            chk("rr_stall", 64'(bus.m_stall), (k % 2 == 0) ? 64'h2 : 64'h1);
            chk("rr_raddr1", bus.s_raddr[64 +: 64], (k % 2 == 0) ? 64'h100 : 64'h200);
            tick();
        end
        idle();

        // Write to slave1 in parallel with a read of slave0
        wr(1, 64'h2000_0000_0000_0008, 64'h0000_0000_CAFE_F00D, 8'h0F);
        rd(0, 64'h0000_0000_0000_0020);
        push(0, 64'h0000_0000_0000_0020);
        mid();
        chk("wr_stall", 64'(bus.m_stall), 64'h0);
        chk("wr_wena", 64'(bus.s_wena), 64'h02);
        chk("wr_rena", 64'(bus.s_rena), 64'h01);
        chk("wr_waddr1", bus.s_waddr[64 +: 64], 64'h8);
        chk("wr_wsel1", 64'(bus.s_wsel[8 +: 8]), 64'h0F);
        chk("wr_wdata1", bus.s_wdata[64 +: 64], 64'h0000_0000_CAFE_F00D);
        tick();
        idle();

        // Simultaneous en_w/en_r on M1: write first, read deferred
        wr(1, 64'h2000_0000_0000_0010, 64'h5555, 8'hFF);
        rd(1, 64'h4000_0000_0000_0018);
        mid();
        chk("rw_stall", 64'(bus.m_stall), 64'h2);
        chk("rw_wena", 64'(bus.s_wena), 64'h02);
        chk("rw_rena", 64'(bus.s_rena), 64'h00);
        tick();
        bus.m_en_w = '0;
        push(1, 64'h4000_0000_0000_0018);
        mid();
        chk("rw2_stall", 64'(bus.m_stall), 64'h0);
        chk("rw2_rena", 64'(bus.s_rena), 64'h04);
        chk("rw2_raddr2", bus.s_raddr[128 +: 64], 64'h18);
        tick();
        idle();

        // Three masters to three distinct slaves in one cycle
        rd(0, 64'h8000_0000_0000_0040);
        rd(1, 64'hA000_0000_0000_0048);
        rd(2, 64'hC000_0000_0000_0050);
        push(0, 64'h8000_0000_0000_0040);
        push(1, 64'hA000_0000_0000_0048);
        push(2, 64'hC000_0000_0000_0050);
        mid();
        chk("par_stall", 64'(bus.m_stall), 64'h0);
        chk("par_rena", 64'(bus.s_rena), 64'h70);
        tick();
        idle();

        // All three masters on slave7: pointer wraps from master 2 to 0
        rd(0, 64'hE000_0000_0000_0100);
        rd(1, 64'hE000_0000_0000_0200);
        rd(2, 64'hE000_0000_0000_0300);
        for (int k = 0; k < 4; k++) begin
            push(k % 3, 64'hE000_0000_0000_0100 + 64'(k % 3) * 64'h100);
            mid();
            chk("wrap_stall", 64'(bus.m_stall), 64'(3'b111 & ~(3'b001 << (k % 3))));
            chk("wrap_raddr7", bus.s_raddr[448 +: 64], 64'h100 + 64'(k % 3) * 64'h100);
            tick();
        end
        idle();
        mid();
        tick();

        // Reset while a granted read is in flight; slave7 pointer is now 1
        rd(0, 64'h6000_0000_0000_0008);
        rd(1, 64'h6000_0000_0000_0010);
        mid();
        chk("rst_grant_rena", 64'(bus.s_rena), 64'h08);
        rst_n = 1'b0;
        idle();
        tick();
        mid();
        chk("rst_rdata0", bus.m_rdata[0 +: 64], 64'h0);
        chk("rst_rdata1", bus.m_rdata[64 +: 64], 64'h0);
        rst_n = 1'b1;
        tick();
        mid();
        tick();
        rd(0, 64'hE000_0000_0000_0100);
        rd(1, 64'hE000_0000_0000_0200);
        rd(2, 64'hE000_0000_0000_0300);
        push(0, 64'hE000_0000_0000_0100);
        mid();
        chk("rst_ptr_stall", 64'(bus.m_stall), 64'h6);
        tick();
        idle();

        // Top-nibble-F read: decode error, or wrap onto slave7
        rd(0, 64'hF000_0000_0000_0000);
`ifdef BUS_XBAR_DECERR_EN
        push_val(0, 64'hDEAD_BEEF_DEAD_BEEF);
        mid();
        chk("de_rena", 64'(bus.s_rena), 64'h0);
        chk("de_stall", 64'(bus.m_stall), 64'h0);
        tick();
        idle();
        mid();
        chk("de_err", 64'(bus.m_err), 64'h1);
        tick();
        mid();
        chk("de_err_clr", 64'(bus.m_err), 64'h0);
        tick();
`else
        push(0, 64'hF000_0000_0000_0000);
        mid();
        chk("wrapidx_rena", 64'(bus.s_rena), 64'h80);
        chk("wrapidx_raddr7", bus.s_raddr[448 +: 64], 64'h1000_0000_0000_0000);
        tick();
        idle();
        mid();
        tick();
`endif

        // Drain: nothing left outstanding
        for (int k = 0; k < 2; k++) begin
            mid();
            tick();
        end
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
